// File: rtl/cae_dispatch_ctl_if.sv
// Dispatch-side bundle between instdec, the CAE dispatch controller and
// the personality datapath. clk and reset stay outside as plain ports.
interface cae_dispatch_ctl_if #(
   parameter int NA = 51,
   parameter int NB = 6,
   parameter int CW = 32
);

   // instdec -> controller
   logic             inst_val;
   logic [4:0]       inst_caep;
   logic             inst_aeg_wr;
   logic             inst_aeg_rd;
   logic [17:0]      inst_aeg_idx;
   logic             err_unimpl_in;
   logic [63:0]      cae_data;

   // datapath -> controller
   logic             hw_we;
   logic [NB-1:0]    hw_idx;
   logic [63:0]      hw_data;
   logic             done;

   // controller -> datapath / host
   logic             start_vld;
   logic [4:0]       start_caep;
   logic [NA*64-1:0] aeg_flat;
   logic [17:0]      cae_aeg_cnt;
   logic [63:0]      cae_ret_data;
   logic             cae_ret_data_vld;
   logic [15:0]      cae_exception;
   logic             cae_idle;
   logic             cae_stall;
   logic [CW-1:0]    last_cycles;

   // the controller itself
   modport slave (
      input  inst_val, inst_caep, inst_aeg_wr, inst_aeg_rd, inst_aeg_idx,
             err_unimpl_in, cae_data, hw_we, hw_idx, hw_data, done,
      output start_vld, start_caep, aeg_flat, cae_aeg_cnt, cae_ret_data,
             cae_ret_data_vld, cae_exception, cae_idle, cae_stall, last_cycles
   );

   // whoever drives instructions and datapath responses
   modport master (
      output inst_val, inst_caep, inst_aeg_wr, inst_aeg_rd, inst_aeg_idx,
             err_unimpl_in, cae_data, hw_we, hw_idx, hw_data, done,
      input  start_vld, start_caep, aeg_flat, cae_aeg_cnt, cae_ret_data,
             cae_ret_data_vld, cae_exception, cae_idle, cae_stall, last_cycles
   );

endinterface

// File: rtl/cae_dispatch_ctl.sv
// CAE dispatch controller: AEG register file with dispatch and datapath
// write ports, one-cycle read return, exception pulses and a busy FSM that
// launches custom instructions and measures how long each one ran.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no instruction running; cae_idle=1, a legal inst_val launches
//   ST_BUSY | datapath executing start_caep; cae_stall=1, waits for done
module cae_dispatch_ctl #(
   parameter int NA    = 51,
   parameter int NB    = 6,
   parameter int NCAEP = 1,
   parameter int CW    = 32
) (
   input logic                clk,
   input logic                i_reset,
   cae_dispatch_ctl_if.slave  bus
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [31:0] NA_U    = 32'(NA);
   localparam logic [31:0] NCAEP_U = 32'(NCAEP);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   state_t        state;
   logic [CW-1:0] cnt;
   logic [63:0]   aeg [NA];

   logic          caep_legal;
   logic          launch_req;
   logic          idx_ok;
   logic          disp_wr;
   logic          disp_rd;
   logic          hw_wr;
   logic [NB-1:0] disp_idx;

   // The index compare is done on the full 18-bit index so that aliasing
   // through the truncated NB-bit field can never hit a real register.
   assign caep_legal = 32'(bus.inst_caep) < NCAEP_U;
   assign launch_req = bus.inst_val && caep_legal;
   assign idx_ok     = 32'(bus.inst_aeg_idx) < NA_U;
   assign disp_wr    = bus.inst_aeg_wr && idx_ok;
   assign disp_rd    = bus.inst_aeg_rd && idx_ok;
   assign hw_wr      = bus.hw_we && (32'(bus.hw_idx) < NA_U);
   assign disp_idx   = bus.inst_aeg_idx[NB-1:0];

   assign bus.cae_aeg_cnt = 18'(NA);

   // AEG file: dispatch write takes priority over a datapath write to the same register
   always_ff @(posedge clk) begin
      if (i_reset) begin
         for (int g = 0; g < NA; g++) begin
            aeg[g] <= '0;
         end
      end else begin
         for (int g = 0; g < NA; g++) begin
            if (disp_wr && (disp_idx == NB'(g))) begin
               aeg[g] <= bus.cae_data;
            end else if (hw_wr && (bus.hw_idx == NB'(g))) begin
               aeg[g] <= bus.hw_data;
            end
         end
      end
   end

   // Flatten the register file for the datapath
   always_comb begin
      bus.aeg_flat = '0;
      for (int g = 0; g < NA; g++) begin
         bus.aeg_flat[g*64 +: 64] = aeg[g];
      end
   end

   // Read return sees the pre-write value; data holds between reads
   always_ff @(posedge clk) begin
      if (i_reset) begin
         bus.cae_ret_data     <= '0;
         bus.cae_ret_data_vld <= 1'b0;
      end else begin
         bus.cae_ret_data_vld <= disp_rd;
         if (disp_rd) begin
            bus.cae_ret_data <= aeg[disp_idx];
         end
      end
   end

   // Exception pulses, each valid for the single cycle after the offending request
   always_ff @(posedge clk) begin
      if (i_reset) begin
         bus.cae_exception <= '0;
      end else begin
         bus.cae_exception[0]     <= bus.err_unimpl_in || (bus.inst_val && !caep_legal);
         bus.cae_exception[1]     <= (bus.inst_aeg_wr || bus.inst_aeg_rd) && !idx_ok;
         bus.cae_exception[2]     <= launch_req && (state == ST_BUSY);
         bus.cae_exception[3]     <= bus.done && (state == ST_IDLE);
         bus.cae_exception[15:4]  <= '0;
      end
   end

   // Busy FSM: launch, count busy cycles, complete on done
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state            <= ST_IDLE;
         cnt              <= '0;
         bus.start_vld    <= 1'b0;
         bus.start_caep   <= '0;
         bus.cae_idle     <= 1'b1;
         bus.cae_stall    <= 1'b0;
         bus.last_cycles  <= '0;
      end else begin
         bus.start_vld <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (launch_req) begin
                  state          <= ST_BUSY;
                  cnt            <= CW'(1);
                  bus.start_vld  <= 1'b1;
                  bus.start_caep <= bus.inst_caep;
                  bus.cae_idle   <= 1'b0;
                  bus.cae_stall  <= 1'b1;
               end
            end
            ST_BUSY: begin
               // done wins over a new inst_val; the latter is only flagged
               if (bus.done) begin
                  state           <= ST_IDLE;
                  bus.last_cycles <= cnt;
                  bus.cae_idle    <= 1'b1;
                  bus.cae_stall   <= 1'b0;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cae_dispatch_ctl.sv
// Self-checking bench for cae_dispatch_ctl: directed scenarios followed by
// random traffic, all compared every cycle against a behavioural model.
module tb_cae_dispatch_ctl;

   localparam int NA    = 51;
   localparam int NB    = 6;
   localparam int NCAEP = 1;
   localparam int CW    = 32;

   logic clk = 1'b0;
   logic i_reset;

   always #5 clk = ~clk;

   cae_dispatch_ctl_if #(.NA(NA), .NB(NB), .CW(CW)) bus ();

   cae_dispatch_ctl #(.NA(NA), .NB(NB), .NCAEP(NCAEP), .CW(CW)) dut (
      .clk     (clk),
      .i_reset (i_reset),
      .bus     (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [63:0]     m_aeg [NA];
   bit              m_busy;
   logic [4:0]      m_caep;
   longint unsigned m_cnt;
   longint unsigned m_last;
   bit              exp_vld;
   logic [63:0]     exp_data;
   logic [15:0]     exp_exc;
   bit              exp_start;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      bus.inst_val      = 1'b0;
      bus.inst_caep     = '0;
      bus.inst_aeg_wr   = 1'b0;
      bus.inst_aeg_rd   = 1'b0;
      bus.inst_aeg_idx  = '0;
      bus.err_unimpl_in = 1'b0;
      bus.cae_data      = '0;
      bus.hw_we         = 1'b0;
      bus.hw_idx        = '0;
      bus.hw_data       = '0;
      bus.done          = 1'b0;
   endtask

   // Advance the model by one clock using the inputs present at the edge
   task automatic model_step();
      int  idx;
      int  hidx;
      int  caep;
      bit  idx_ok;
      bit  legal;
      if (i_reset) begin
         for (int g = 0; g < NA; g++) m_aeg[g] = '0;
         m_busy    = 0;
         m_caep    = '0;
         m_cnt     = 0;
         m_last    = 0;
         exp_vld   = 0;
         exp_data  = '0;
         exp_exc   = '0;
         exp_start = 0;
         return;
      end
      idx    = int'(bus.inst_aeg_idx);
      hidx   = int'(bus.hw_idx);
      caep   = int'(bus.inst_caep);
      idx_ok = idx < NA;
      legal  = bus.inst_val && (caep < NCAEP);

      exp_exc    = '0;
      exp_exc[0] = bus.err_unimpl_in || (bus.inst_val && caep >= NCAEP);
      exp_exc[1] = (bus.inst_aeg_wr || bus.inst_aeg_rd) && !idx_ok;
      exp_exc[2] = legal && m_busy;
      exp_exc[3] = bus.done && !m_busy;

      exp_vld = bus.inst_aeg_rd && idx_ok;
      if (exp_vld) exp_data = m_aeg[idx];

      if (bus.hw_we && hidx < NA) m_aeg[hidx] = bus.hw_data;
      if (bus.inst_aeg_wr && idx_ok) m_aeg[idx] = bus.cae_data;

      exp_start = 0;
      if (m_busy) begin
         if (bus.done) begin
            m_busy = 0;
            m_last = m_cnt;
         end else if (m_cnt < 64'hFFFF_FFFF) begin
            m_cnt++;
         end
      end else if (legal) begin
         m_busy    = 1;
         m_caep    = bus.inst_caep;
         m_cnt     = 1;
         exp_start = 1;
      end
   endtask

   task automatic check_outputs();
      check_val("ret_vld",   64'(bus.cae_ret_data_vld), 64'(exp_vld));
      check_val("ret_data",  bus.cae_ret_data, exp_data);
      check_val("exception", 64'(bus.cae_exception), 64'(exp_exc));
      check_val("start_vld", 64'(bus.start_vld), 64'(exp_start));
      check_val("start_caep",64'(bus.start_caep), 64'(m_caep));
      check_val("idle",      64'(bus.cae_idle), 64'(!m_busy));
      check_val("stall",     64'(bus.cae_stall), 64'(m_busy));
      check_val("last_cyc",  64'(bus.last_cycles), m_last);
      for (int g = 0; g < NA; g++) begin
         check_val($sformatf("aeg%0d", g), bus.aeg_flat[g*64 +: 64], m_aeg[g]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   initial begin
      int busy_cycles;

      // reset
      clear_inputs();
      i_reset = 1'b1;
      step();
      step();
      i_reset = 1'b0;
      check_val("rst_idle",    64'(bus.cae_idle), 64'd1);
      check_val("rst_stall",   64'(bus.cae_stall), 64'd0);
      check_val("rst_exc",     64'(bus.cae_exception), 64'd0);
      check_val("rst_last",    64'(bus.last_cycles), 64'd0);
      check_val("aeg_cnt",     64'(bus.cae_aeg_cnt), 64'd51);

      // write AEG 5 then read it back
      bus.inst_aeg_wr  = 1'b1;
      bus.inst_aeg_idx = 18'd5;
      bus.cae_data     = 64'hDEADBEEF_00000001;
      step();
      clear_inputs();
      bus.inst_aeg_rd  = 1'b1;
      bus.inst_aeg_idx = 18'd5;
      step();
      clear_inputs();
      check_val("rd5_vld",  64'(bus.cae_ret_data_vld), 64'd1);
      check_val("rd5_data", bus.cae_ret_data, 64'hDEADBEEF_00000001);
      check_val("aeg5_flat", bus.aeg_flat[383:320], 64'hDEADBEEF_00000001);
      step();
      check_val("rd5_vld_drop", 64'(bus.cae_ret_data_vld), 64'd0);

      // out-of-range read and write
      bus.inst_aeg_rd  = 1'b1;
      bus.inst_aeg_idx = 18'd51;
      step();
      check_val("rd51_exc", 64'(bus.cae_exception), 64'd2);
      check_val("rd51_vld", 64'(bus.cae_ret_data_vld), 64'd0);
      clear_inputs();
      bus.inst_aeg_wr  = 1'b1;
      bus.inst_aeg_idx = 18'd60;
      bus.cae_data     = 64'h1234;
      step();
      check_val("wr60_exc", 64'(bus.cae_exception), 64'd2);
      clear_inputs();
      step();
      check_val("exc_one_pulse", 64'(bus.cae_exception), 64'd0);

      // launch caep 0, done 4 cycles after start_vld
      bus.inst_val  = 1'b1;
      bus.inst_caep = 5'd0;
      step();
      clear_inputs();
      check_val("launch_start", 64'(bus.start_vld), 64'd1);
      busy_cycles = (bus.cae_idle == 1'b0 && bus.cae_stall == 1'b1) ? 1 : 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (bus.cae_idle == 1'b0 && bus.cae_stall == 1'b1) busy_cycles++;
      end
      bus.done = 1'b1;
      step();
      clear_inputs();
      check_val("busy_len",  64'(busy_cycles), 64'd5);
      check_val("last_5",    64'(bus.last_cycles), 64'd5);
      check_val("idle_back", 64'(bus.cae_idle), 64'd1);

      // same-index collision, dispatch wins
      bus.inst_aeg_wr  = 1'b1;
      bus.inst_aeg_idx = 18'd3;
      bus.cae_data     = 64'h22;
      bus.hw_we        = 1'b1;
      bus.hw_idx       = 6'd3;
      bus.hw_data      = 64'h11;
      step();
      clear_inputs();
      check_val("aeg3_disp", bus.aeg_flat[3*64 +: 64], 64'h22);
      bus.hw_we   = 1'b1;
      bus.hw_idx  = 6'd3;
      bus.hw_data = 64'h33;
      step();
      clear_inputs();
      check_val("aeg3_hw", bus.aeg_flat[3*64 +: 64], 64'h33);

      // illegal caep, overlap, spurious done
      bus.inst_val  = 1'b1;
      bus.inst_caep = 5'd2;
      step();
      clear_inputs();
      check_val("caep2_exc",  64'(bus.cae_exception), 64'd1);
      check_val("caep2_idle", 64'(bus.cae_idle), 64'd1);
      bus.inst_val = 1'b1;
      step();
      bus.done = 1'b1;
      step();
      clear_inputs();
      check_val("overlap_exc", 64'(bus.cae_exception), 64'd4);
      check_val("last_1",      64'(bus.last_cycles), 64'd1);
      bus.done = 1'b1;
      step();
      clear_inputs();
      check_val("spur_done_exc", 64'(bus.cae_exception), 64'd8);

      // reset while busy
      bus.inst_val = 1'b1;
      step();
      clear_inputs();
      step();
      step();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      check_val("rstb_idle",  64'(bus.cae_idle), 64'd1);
      check_val("rstb_stall", 64'(bus.cae_stall), 64'd0);
      check_val("rstb_aeg",   64'(|bus.aeg_flat), 64'd0);
      bus.done = 1'b1;
      step();
      clear_inputs();
      check_val("rstb_done_exc", 64'(bus.cae_exception), 64'd8);

      // random traffic
      for (int n = 0; n < 2000; n++) begin
         i_reset           = ($urandom_range(0, 199) == 0);
         bus.inst_val      = ($urandom_range(0, 3) == 0);
         bus.inst_caep     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
         bus.inst_aeg_wr   = ($urandom_range(0, 2) == 0);
         bus.inst_aeg_rd   = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 7))
            0:       bus.inst_aeg_idx = 18'($urandom_range(0, 262143));
            1:       bus.inst_aeg_idx = 18'($urandom_range(NA - 2, NA + 1));
            default: bus.inst_aeg_idx = 18'($urandom_range(0, NA - 1));
         endcase
         bus.err_unimpl_in = ($urandom_range(0, 19) == 0);
         bus.cae_data      = {$urandom, $urandom};
         bus.hw_we         = ($urandom_range(0, 1) == 0);
         bus.hw_idx        = ($urandom_range(0, 3) == 0) ? bus.inst_aeg_idx[NB-1:0]
                                                          : NB'($urandom_range(0, 63));
         bus.hw_data       = {$urandom, $urandom};
         bus.done          = ($urandom_range(0, 4) == 0);
         step();
      end
      i_reset = 1'b0;
      clear_inputs();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cae_dispatch_ctl.md
Name: cae_dispatch_ctl

Overview:
Parametrised dispatch controller for a CAE personality. It owns the AEG register file, the AEG read-return path and the exception reporting. It also launches multi-cycle custom instructions, drives cae_idle and cae_stall from a busy FSM, and lets the personality datapath write result AEGs back. It sits between instdec and the personality datapath, and it supersedes the fixed always-idle dispatch logic.

Parameters:
NA, 51, number of AEG registers (1..2^NB)
NB, 6, AEG index bits actually decoded
NCAEP, 1, number of implemented custom instructions; caep values 0..NCAEP-1 are legal
CW, 32, width of the busy-cycle counter

Ports:
clk  in  1  personality clock
i_reset  in  1  synchronous active-high reset
inst_val  in  1  custom instruction valid (from instdec)
inst_caep  in  5  custom instruction number
inst_aeg_wr  in  1  AEG write request
inst_aeg_rd  in  1  AEG read request
inst_aeg_idx  in  18  AEG index
err_unimpl_in  in  1  unimplemented-instruction flag from instdec
cae_data  in  64  dispatch write data
hw_we  in  1  datapath AEG write enable
hw_idx  in  NB  datapath AEG index
hw_data  in  64  datapath AEG write data
done  in  1  datapath completion pulse
start_vld  out  1  one-cycle launch pulse to datapath
start_caep  out  5  caep of the launched instruction, held while busy
aeg_flat  out  NA*64  all AEG values; register g occupies bits [64g+63:64g]
cae_aeg_cnt  out  18  constant NA
cae_ret_data  out  64  read-return data
cae_ret_data_vld  out  1  read-return valid
cae_exception  out  16  exception bits
cae_idle  out  1  high when no custom instruction is executing
cae_stall  out  1  high while a custom instruction is executing
last_cycles  out  CW  busy-cycle count of the last completed instruction

Behaviour:
- All logic runs on clk. Reset is synchronous, active-high, single-cycle sufficient.
- Reset values:
  - all AEGs 0
  - cae_ret_data 0, cae_ret_data_vld 0
  - cae_exception 0
  - start_vld 0, start_caep 0
  - cae_idle 1, cae_stall 0
  - last_cycles 0
  - FSM in IDLE
- AEG write:
  - A dispatch write occurs when inst_aeg_wr is high and inst_aeg_idx < NA. It updates AEG[idx[NB-1:0]] at the next edge.
  - A datapath write occurs when hw_we is high and hw_idx < NA. It updates AEG[hw_idx] at the next edge.
  - Same index in the same cycle: the dispatch write wins. Different indices: both writes take effect.
  - hw_idx >= NA: the write is silently dropped.
- AEG read:
  - inst_aeg_rd with idx < NA gives cae_ret_data_vld = 1 for exactly one cycle, on the edge after the request (latency 1).
  - cae_ret_data carries the register value from before any same-cycle write (read-before-write).
  - cae_ret_data holds its value when vld is low.
- Exceptions: all bits are registered one-cycle pulses, latency 1.
  - bit0: err_unimpl_in, or (inst_val and inst_caep >= NCAEP).
  - bit1: (inst_aeg_wr or inst_aeg_rd) and inst_aeg_idx >= NA. No write and no return occur.
  - bit2: inst_val with a legal caep while BUSY (overlap). The instruction is ignored.
  - bit3: done asserted while IDLE (spurious done). It is ignored.
  - bits 15:4 are 0.
- FSM with states IDLE and BUSY:
  - IDLE -> BUSY on inst_val with inst_caep < NCAEP. On that edge: start_caep latches inst_caep, start_vld goes high for one cycle, cae_idle goes to 0, cae_stall goes to 1, and the counter clears to 1.
  - In BUSY the counter increments each cycle and saturates at 2^CW-1.
  - BUSY -> IDLE on done. On that edge: last_cycles latches the counter, cae_idle goes to 1, and cae_stall goes to 0.
  - done is honoured in the same cycle that start_vld is high, giving a minimum BUSY of 1 cycle and last_cycles = 1.
- AEG reads and writes are serviced in both states.
- Reset in BUSY: the FSM returns to IDLE with no start or done side effects, and any pending done is discarded.
- Simultaneous inst_val and done in BUSY: done completes and the new instruction is flagged as an overlap (bit2). It is not launched.

Test Plan:
- Reset, then write 0xDEADBEEF_00000001 to AEG 5 and read AEG 5 -> cae_ret_data_vld is high for one cycle, the cycle after the read, with data 0xDEADBEEF_00000001; aeg_flat[383:320] matches.
- Read idx 51 and write idx 60 -> exception bit1 pulses once per request; no vld; no AEG changes.
- inst_val with caep 0, done 4 cycles after start_vld -> start_vld is a one-cycle pulse; idle=0 and stall=1 for exactly 5 cycles; last_cycles = 5.
- In the same cycle, hw_we and the dispatch write both target idx 3 (hw 0x11, dispatch 0x22) -> AEG3 = 0x22. Next cycle, hw_we alone to idx 3 with 0x33 -> AEG3 = 0x33.
- caep 2 with NCAEP=1 -> exception bit0, FSM stays IDLE. Legal inst_val while BUSY -> bit2. done while IDLE -> bit3.
- Assert i_reset 2 cycles into BUSY -> next cycle idle=1, stall=0, all AEGs 0; a later done raises bit3.
